da_conv_engine: RTL

Runtime-configurable successor to the fixed-weight distributed-arithmetic (DA) 1-D convolution core. It computes a KERNEL_H-tap dot product of unsigned pixels with signed coefficients. The bit-slice LUT is held in registers and rebuilt by an internal FSM whenever new coefficients are loaded. It sits in a separable-convolution row/column processing element, with valid/ready handshakes on both the data stream and the configuration port.

---
 rtl/da_conv_pkg.sv | 27 ++
 rtl/da_lut_builder.sv | 63 ++++++
 rtl/da_conv_engine.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/da_conv_pkg.sv
// Shared widths, helpers and FSM encoding for the DA convolution engine.
package da_conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Tap-index width; also the LUT growth over COEF_W (never less than one bit).
  function automatic int tap_w(input int k);
    return (clog2(k) < 1) ? 1 : clog2(k);
  endfunction

  function automatic int lut_w(input int coef_w, input int k);
    return coef_w + tap_w(k);
  endfunction

  function automatic int acc_w(input int coef_w, input int k, input int data_w);
    return lut_w(coef_w, k) + data_w;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, BUILD} conv_state_e;

endpackage

// File: rtl/da_lut_builder.sv
// Coefficient shadow registers, incremental LUT builder and DATA_W read ports.
module da_lut_builder
  import da_conv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int KERNEL_H = 7,
  parameter int COEF_W   = 5,
  parameter int TAP_W    = tap_w(KERNEL_H),
  parameter int LUT_W    = lut_w(COEF_W, KERNEL_H)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              cfg_we,
  input  logic [TAP_W-1:0]                  cfg_idx,
  input  logic [COEF_W-1:0]                 cfg_coef,
  input  logic                              build_en,
  output logic                              build_last,
  input  logic [DATA_W-1:0][KERNEL_H-1:0]   rd_addr,
  output logic [DATA_W-1:0][LUT_W-1:0]      rd_data
);

  localparam int LUT_N = 1 << KERNEL_H;

  logic [KERNEL_H-1:0][COEF_W-1:0] coef;
  logic [LUT_N-1:0][LUT_W-1:0]     lut;
  logic [KERNEL_H-1:0]             idx;

  function automatic logic [TAP_W-1:0] ctz(input logic [KERNEL_H-1:0] v);
    logic [TAP_W-1:0] r;
    r = '0;
    for (int i = KERNEL_H - 1; i >= 0; i--)
      if (v[i]) r = TAP_W'(i);
    return r;
  endfunction

  function automatic logic [LUT_W-1:0] sext(input logic [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

  assign build_last = build_en && (idx == '1);

  // Each entry differs from an already-built one by its lowest set bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coef <= '0;
      lut  <= '0;
      idx  <= KERNEL_H'(1);
    end else begin
      if (cfg_we) coef[cfg_idx] <= cfg_coef;
      if (build_en) begin
        lut[idx] <= lut[idx & (idx - KERNEL_H'(1))] + sext(coef[ctz(idx)]);
        idx      <= idx + KERNEL_H'(1);
      end else begin
        idx <= KERNEL_H'(1);
      end
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_rd
    assign rd_data[b] = lut[rd_addr[b]];
  end

endmodule

// File: rtl/da_conv_engine.sv
// Runtime-configurable distributed-arithmetic 1-D convolution, three-stage pipeline.
module da_conv_engine
  import da_conv_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int KERNEL_H = 7,
  parameter int COEF_W   = 5,
  parameter int NORM_W   = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [KERNEL_H*DATA_W-1:0] i_in_vector,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [DATA_W-1:0]          o_out_data,
  input  logic                       i_cfg_valid,
  output logic                       o_cfg_ready,
  input  logic [COEF_W-1:0]          i_cfg_coef,
  input  logic [NORM_W-1:0]          i_cfg_norm,
  input  logic                       i_cfg_round,
  output logic                       o_busy
);

  localparam int TAP_W  = tap_w(KERNEL_H);
  localparam int LUT_W  = lut_w(COEF_W, KERNEL_H);
  localparam int ACC_W  = acc_w(COEF_W, KERNEL_H, DATA_W);
  localparam int STAGES = 3;

  conv_state_e       state;
  logic [TAP_W-1:0]  beat_cnt;
  logic [NORM_W-1:0] norm_sh, norm_act;
  logic              rnd_sh, rnd_act;
  logic [STAGES:1]   vld_pipe;

  logic cfg_fire, last_beat, in_fire, advance, build_last;

  logic [DATA_W-1:0][KERNEL_H-1:0] rd_addr;
  logic [DATA_W-1:0][LUT_W-1:0]    rd_data, s1_ent;
  logic signed [ACC_W-1:0]         wsum, s2_acc;
  logic signed [ACC_W:0]           rnd_add, rnd_sum, shifted;
  logic [DATA_W-1:0]               sat;

  assign o_cfg_ready = (state == IDLE) || (state == LOAD);
  assign o_busy      = (state == DRAIN) || (state == BUILD);
  assign o_out_valid = vld_pipe[STAGES];
  assign advance     = !o_out_valid || i_out_ready;
  assign o_in_ready  = o_cfg_ready && advance;
  assign in_fire     = i_in_valid && o_in_ready;
  assign cfg_fire    = i_cfg_valid && o_cfg_ready;
  assign last_beat   = cfg_fire && (beat_cnt == TAP_W'(KERNEL_H - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      norm_sh  <= '0;
      rnd_sh   <= 1'b0;
      norm_act <= '0;
      rnd_act  <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (last_beat) begin
            state    <= DRAIN;
            beat_cnt <= '0;
            norm_sh  <= i_cfg_norm;
            rnd_sh   <= i_cfg_round;
          end else if (cfg_fire) begin
            state    <= LOAD;
            beat_cnt <= beat_cnt + TAP_W'(1);
          end
        end
        DRAIN: begin
          // In-flight vectors finish under the old LUT and normalisation.
          if (vld_pipe == '0) begin
            state    <= BUILD;
            norm_act <= norm_sh;
            rnd_act  <= rnd_sh;
          end
        end
        BUILD:   if (build_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  da_lut_builder #(
    .DATA_W   (DATA_W),
    .KERNEL_H (KERNEL_H),
    .COEF_W   (COEF_W),
    .TAP_W    (TAP_W),
    .LUT_W    (LUT_W)
  ) u_lut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .cfg_we     (cfg_fire),
    .cfg_idx    (beat_cnt),
    .cfg_coef   (i_cfg_coef),
    .build_en   (state == BUILD),
    .build_last (build_last),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  for (genvar b = 0; b < DATA_W; b++) begin : g_slice
    for (genvar p = 0; p < KERNEL_H; p++) begin : g_tap
      assign rd_addr[b][p] = i_in_vector[p*DATA_W + b];
    end
  end

  always_comb begin
    wsum = '0;
    for (int b = 0; b < DATA_W; b++)
      wsum = wsum + ({{DATA_W{s1_ent[b][LUT_W-1]}}, s1_ent[b]} << b);
  end

  // One guard bit so the rounding add cannot wrap.
  always_comb begin
    rnd_add = '0;
    if (rnd_act && (norm_act != '0))
      rnd_add = (ACC_W+1)'(1) << (norm_act - NORM_W'(1));
    rnd_sum = $signed({s2_acc[ACC_W-1], s2_acc}) + rnd_add;
    shifted = rnd_sum >>> norm_act;
    if (shifted[ACC_W])                 sat = '0;
    else if (|shifted[ACC_W-1:DATA_W])  sat = '1;
    else                                sat = shifted[DATA_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe   <= '0;
      s1_ent     <= '0;
      s2_acc     <= '0;
      o_out_data <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
      if (in_fire)     s1_ent     <= rd_data;
      if (vld_pipe[1]) s2_acc     <= wsum;
      if (vld_pipe[2]) o_out_data <= sat;
    end
  end

endmodule
